// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic stream decoder.
// Optional build macro: SC_DECODE_BIPOLAR_EN selects a signed bipolar output.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } sc_dec_state_t;

  // Ceiling log2, used for elaboration-time width math only.
  function automatic int sc_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Width of the emitted count; the bipolar form needs one extra sign bit.
  function automatic int sc_count_width(input int window_log2);
`ifdef SC_DECODE_BIPOLAR_EN
    return window_log2 + 2;
`else
    return window_log2 + 1;
`endif
  endfunction

  // Map a ones count over an n-sample window onto the bipolar range -n..n.
  function automatic int sc_unipolar_to_bipolar(input int ones, input int n);
    return (2 * ones) - n;
  endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Stream-in / count-out bundle of the stochastic stream decoder.
// The count width grows by one bit when SC_DECODE_BIPOLAR_EN is defined.
interface sc_stream_decoder_if
  import sc_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8
);

  localparam int COUNT_W = sc_count_width(WINDOW_LOG2);

  logic               start;
  logic               continuous;
  logic               in_bit;
  logic               in_valid;
  logic [COUNT_W-1:0] out_count;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               overrun;

  modport master (
    output start, continuous, in_bit, in_valid, out_ready,
    input  out_count, out_valid, busy, overrun
  );

  modport slave (
    input  start, continuous, in_bit, in_valid, out_ready,
    output out_count, out_valid, busy, overrun
  );

endinterface

// File: rtl/sc_window_counter.sv
// Sample and ones counters for one decoding window.
// last_sample flags that the next enabled sample completes the window.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter  int WINDOW_LOG2 = 8,
  localparam int OUT_WIDTH   = WINDOW_LOG2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 in_bit,
  output logic [OUT_WIDTH-1:0] ones_next,
  output logic                 last_sample
);

  localparam int CNT_W = sc_clog2(1 << WINDOW_LOG2);

  logic [CNT_W-1:0]     sample_cnt;
  logic [OUT_WIDTH-1:0] ones_cnt;

  assign ones_next   = ones_cnt + OUT_WIDTH'(in_bit);
  assign last_sample = &sample_cnt;

  // Count valid samples; the completing sample wraps both counters back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
    end else if (enable) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      ones_cnt   <= last_sample ? '0 : ones_next;
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WINDOW_LOG2 valid samples
// and holds the count under a valid/ready handshake.
// Build macro SC_DECODE_BIPOLAR_EN emits the signed value 2*ones - N instead.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter  int WINDOW_LOG2 = 8,
  localparam int OUT_WIDTH   = WINDOW_LOG2 + 1
) (
  input logic             clk,
  input logic             rst,
  sc_stream_decoder_if.slave bus
);

  localparam int N       = 1 << WINDOW_LOG2;
  localparam int COUNT_W = sc_count_width(WINDOW_LOG2);

  sc_dec_state_t        state;
  logic [COUNT_W-1:0]   count_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 overrun_q;
  logic [OUT_WIDTH-1:0] ones_next;
  logic                 last_sample;
  logic                 accept_start;
  logic                 cnt_enable;
  logic [COUNT_W-1:0]   result_value;

  // start is honoured only outside HOLD; a sample coinciding with start is dropped.
  assign accept_start = bus.start && (state == IDLE || state == ACCUM);
  assign cnt_enable   = (state == ACCUM) && bus.in_valid && !bus.start;

`ifdef SC_DECODE_BIPOLAR_EN
  assign result_value = COUNT_W'(sc_unipolar_to_bipolar(int'(ones_next), N));
`else
  assign result_value = ones_next;
`endif

  sc_window_counter #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_window_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept_start),
    .enable     (cnt_enable),
    .in_bit     (bus.in_bit),
    .ones_next  (ones_next),
    .last_sample(last_sample)
  );

  assign bus.out_count = count_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

  // Window control, result register, handshake and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= ACCUM;
            busy_q    <= 1'b1;
            overrun_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (bus.start) begin
            overrun_q <= 1'b0;
          end else if (bus.in_valid && last_sample) begin
            count_q <= result_value;
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.in_valid) overrun_q <= 1'b1;
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (bus.continuous) begin
              state <= ACCUM;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter: counts the 1s in a stochastic bitstream over a fixed window of 2^WINDOW_LOG2 valid samples and emits the binary count.
- Sits downstream of sc_dot_product, consuming its result/valid pair. It returns the computed value to the binary domain for checking or for the next layer.
- Output is held under a valid/ready handshake.

Parameters:
- WINDOW_LOG2, 8, log2 of the window length N (N = 256 by default). Legal range 2..16.
- OUT_WIDTH, WINDOW_LOG2+1, width of out_count. Must hold N exactly. Fixed derivation, not user-overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; clears the counters and opens a new window.
- continuous  in  1  1 = the next window opens automatically after each handshake; 0 = return to IDLE.
- in_bit  in  1  stochastic stream bit (sc_dot_product result).
- in_valid  in  1  in_bit is a valid sample this cycle (sc_dot_product valid).
- out_count  out  OUT_WIDTH  number of 1s in the completed window, 0..N.
- out_valid  out  1  out_count is valid; held until accepted.
- out_ready  in  1  consumer accepts out_count.
- busy  out  1  high in ACCUM or HOLD.
- overrun  out  1  sticky; set when a sample arrives while in HOLD.

Behaviour:
- Reset: state=IDLE; sample counter, ones counter, out_count = 0; out_valid=0, busy=0, overrun=0.
- Sample counter width is WINDOW_LOG2; ones counter width is OUT_WIDTH.
- State IDLE:
  - start=1 -> ACCUM, counters cleared.
  - in_valid is ignored in IDLE; overrun is not set.
- State ACCUM:
  - On each in_valid=1: sample_cnt += 1; ones_cnt += in_bit.
  - When in_valid=1 and sample_cnt == N-1, the window completes: out_count <= ones_cnt + in_bit; counters cleared; -> HOLD; out_valid=1 the next cycle.
  - Latency: out_valid rises exactly 1 cycle after the last sample is accepted.
  - in_valid gaps stall counting without error; the window counts valid samples, not cycles.
  - start=1 in ACCUM restarts the window: counters cleared, and any in_valid sample in the same cycle is discarded.
- State HOLD:
  - out_valid=1 and out_count are stable until out_valid & out_ready.
  - On the handshake cycle: out_valid <= 0. Then -> ACCUM if continuous=1, else -> IDLE. A new window's first sample is accepted from the cycle after the handshake.
  - in_valid=1 in HOLD: sample dropped, overrun <= 1.
  - start in HOLD is ignored.
- overrun is cleared only by rst or by an accepted start (IDLE or ACCUM).
- out_ready is ignored when out_valid=0.
- rst mid-operation overrides everything: an in-progress window and any held output are discarded.
- No arithmetic overflow is possible: ones_cnt ≤ N fits OUT_WIDTH bits.

Optional Feature:
- Macro: SC_DECODE_BIPOLAR_EN.
- Defined:
  - out_count is reinterpreted as a signed two's-complement value 2*ones − N, range −N..N.
  - out_count width becomes OUT_WIDTH+1.
  - The conversion is registered in the same cycle the window completes, so latency is unchanged.
- Undefined: unipolar unsigned count as specified above.
- The handshake and state machine are identical in both builds.

Decomposition:
- Shared package sc_pkg holds:
  - state enum sc_dec_state_t {IDLE, ACCUM, HOLD};
  - a clog2 helper function;
  - bipolar conversion function sc_unipolar_to_bipolar(ones, N).
- One sub-module, sc_window_counter:
  - sample counter plus ones counter with clear/enable;
  - outputs ones_next and last_sample (terminal-count) flag;
  - sc_stream_decoder contains the FSM, output register, handshake and overrun logic.

Test Plan (WINDOW_LOG2=4, N=16 unless noted):
- start, then 16 consecutive in_valid=1 with in_bit=1, out_ready=1 -> out_valid 1 cycle after 16th sample, out_count=16, busy falls next cycle with continuous=0.
- Alternating in_bit 1/0 with in_valid deasserted every third cycle -> out_count=8 after exactly 16 valid samples; cycle count between start and out_valid matches the gap pattern.
- continuous=1, out_ready held 0 for 5 cycles while in_valid=1 -> out_count stable through the stall, overrun=1. After the handshake the next window counts only samples after the handshake.
- start mid-window after 10 samples (6 ones) -> counters cleared; the next 16 samples of all zeros give out_count=0.
- rst asserted in HOLD with out_valid=1 -> next cycle out_valid=0, busy=0, overrun=0, out_count=0; in_valid ignored until start.
- SC_DECODE_BIPOLAR_EN defined:
  - all-zero window -> out_count=−16;
  - 12 ones -> +8;
  - 8 ones -> 0.
